// File: rtl/cr_kme_kop_kdf_msg_packer.sv
// cr_kme_kop_kdf_msg_packer
// Packs a byte stream of msg_len bytes into 512-bit SHA-256 message blocks,
// appending the standard 0x80 marker, zero fill and 64-bit big-endian bit
// length. Up to 16 bytes are taken from the upstream pipe per cycle. Each
// completed block is presented on a valid/ready handshake.
//
// Optional feature: define CR_KME_KDF_PACKER_ERR_CHK_EN to enable the sticky
// protocol error flag (msg_start while busy, or a 1024-cycle stream stall in
// FILL). When the macro is undefined, err is tied low.
module cr_kme_kop_kdf_msg_packer #(
    parameter int AVAIL_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_start,
    input  logic [15:0]        msg_len,
    output logic               msg_busy,
    input  logic               pipe_valid,
    input  logic [127:0]       pipe_data,
    input  logic [AVAIL_W-1:0] pipe_avail_bytes,
    output logic               pipe_ack,
    output logic [4:0]         pipe_ack_num_bytes,
    output logic               blk_valid,
    output logic [511:0]       blk_data,
    output logic               blk_last,
    input  logic               blk_ready,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD  = 3'd2,
        LEN  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [6:0]   offset;
    logic [6:0]   offset_nxt;
    logic [15:0]  remain;
    logic [15:0]  remain_nxt;
    logic [15:0]  total_len;
    logic [15:0]  total_nxt;
    logic [511:0] blk_buf;
    logic [511:0] buf_nxt;
    logic         last_q;
    logic         last_nxt;
    logic         pend_len;
    logic         pend_len_nxt;
    logic         pend_pad;
    logic         pend_pad_nxt;
    logic [4:0]   ack_n;

    // Number of bytes that can be taken this cycle: limited by the 16-byte
    // pipe width, what upstream holds, room left in the block and the bytes
    // still owed to the message.
    function automatic logic [4:0] ack_count(
        input logic [AVAIL_W-1:0] avail,
        input logic [6:0]         off,
        input logic [15:0]        rem
    );
        logic [4:0]  n;
        logic [6:0]  space;
        logic [15:0] av;
        n     = 5'd16;
        av    = 16'(avail);
        space = 7'd64 - off;
        if (av < {11'd0, n}) begin
            n = av[4:0];
        end
        if (space < {2'd0, n}) begin
            n = space[4:0];
        end
        if (rem < {11'd0, n}) begin
            n = rem[4:0];
        end
        return n;
    endfunction

    // Message length in bits as the 64-bit big-endian trailer value.
    function automatic logic [63:0] bit_len(input logic [15:0] len);
        return {45'd0, len, 3'd0};
    endfunction

    assign ack_n     = ack_count(pipe_avail_bytes, offset, remain);
    assign msg_busy  = (state != IDLE);
    assign blk_valid = (state == OUT);
    assign blk_data  = blk_buf;
    assign blk_last  = last_q;

    // Next-state, block assembly and stream-ack decode.
    always_comb begin
        state_nxt          = state;
        offset_nxt         = offset;
        remain_nxt         = remain;
        total_nxt          = total_len;
        buf_nxt            = blk_buf;
        last_nxt           = last_q;
        pend_len_nxt       = pend_len;
        pend_pad_nxt       = pend_pad;
        pipe_ack           = 1'b0;
        pipe_ack_num_bytes = 5'd0;

        case (state)
            IDLE: begin
                if (msg_start) begin
                    total_nxt    = msg_len;
                    remain_nxt   = msg_len;
                    offset_nxt   = 7'd0;
                    buf_nxt      = '0;
                    last_nxt     = 1'b0;
                    pend_len_nxt = 1'b0;
                    pend_pad_nxt = 1'b0;
                    state_nxt    = (msg_len == 16'd0) ? PAD : FILL;
                end
            end

            FILL: begin
                if (pipe_valid && (pipe_avail_bytes != '0)) begin
                    pipe_ack           = 1'b1;
                    pipe_ack_num_bytes = ack_n;
                    for (int i = 0; i < 16; i++) begin
                        if (i < int'(ack_n)) begin
                            buf_nxt[(63 - (int'(offset) + i)) * 8 +: 8] =
                                pipe_data[(15 - i) * 8 +: 8];
                        end
                    end
                    offset_nxt = offset + {2'd0, ack_n};
                    remain_nxt = remain - {11'd0, ack_n};
                    if (remain_nxt == 16'd0) begin
                        if (offset_nxt == 7'd64) begin
                            // Data exactly fills the block: ship it, pad after.
                            pend_pad_nxt = 1'b1;
                            state_nxt    = OUT;
                        end else begin
                            state_nxt = PAD;
                        end
                    end else if (offset_nxt == 7'd64) begin
                        state_nxt = OUT;
                    end
                end
            end

            PAD: begin
                for (int b = 0; b < 64; b++) begin
                    if (b == int'(offset)) begin
                        buf_nxt[(63 - b) * 8 +: 8] = 8'h80;
                    end else if (b > int'(offset)) begin
                        buf_nxt[(63 - b) * 8 +: 8] = 8'h00;
                    end
                end
                if (offset <= 7'd55) begin
                    // Marker leaves room for the length trailer in this block.
                    buf_nxt[63:0] = bit_len(total_len);
                    last_nxt      = 1'b1;
                end else begin
                    pend_len_nxt = 1'b1;
                end
                pend_pad_nxt = 1'b0;
                state_nxt    = OUT;
            end

            LEN: begin
                buf_nxt      = {448'd0, bit_len(total_len)};
                last_nxt     = 1'b1;
                pend_len_nxt = 1'b0;
                state_nxt    = OUT;
            end

            OUT: begin
                if (blk_ready) begin
                    offset_nxt = 7'd0;
                    buf_nxt    = '0;
                    last_nxt   = 1'b0;
                    if (last_q) begin
                        state_nxt = IDLE;
                    end else if (pend_len) begin
                        state_nxt = LEN;
                    end else if (pend_pad) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and block buffer registers; reset discards any in-flight message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            offset    <= 7'd0;
            remain    <= 16'd0;
            total_len <= 16'd0;
            blk_buf   <= '0;
            last_q    <= 1'b0;
            pend_len  <= 1'b0;
            pend_pad  <= 1'b0;
        end else begin
            state     <= state_nxt;
            offset    <= offset_nxt;
            remain    <= remain_nxt;
            total_len <= total_nxt;
            blk_buf   <= buf_nxt;
            last_q    <= last_nxt;
            pend_len  <= pend_len_nxt;
            pend_pad  <= pend_pad_nxt;
        end
    end

`ifdef CR_KME_KDF_PACKER_ERR_CHK_EN
    logic       err_q;
    logic [9:0] stall_cnt;

    // Sticky protocol error: restart while busy, or stream starved for
    // 1024 consecutive cycles while waiting for message bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            stall_cnt <= 10'd0;
        end else begin
            if ((state == FILL) && !pipe_valid) begin
                stall_cnt <= stall_cnt + 10'd1;
            end else begin
                stall_cnt <= 10'd0;
            end
            if ((msg_start && (state != IDLE)) ||
                ((state == FILL) && !pipe_valid && (stall_cnt == 10'd1023))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
